instr_decoder_fsm: RTL and testbench

Parametrised next-generation instruction decoder between the instruction register and the execution units (ALU, MOV path, load/store unit).
Accepts one instruction word per valid/ready handshake and splits it into registered fields.
Raises exactly one class strobe, held until the addressed unit acknowledges or a timeout expires.
Replaces sticky class flags with a handshaked, self-clearing issue sequence.

---
 rtl/instr_decoder_fsm.sv | 158 +++++++++++++++
 tb/tb_instr_decoder_fsm.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/instr_decoder_fsm.sv
// Instruction decoder: registers instruction fields and issues one handshaked class strobe.
// Optional DEC_ILLEGAL_TRAP_EN: undefined opcodes park in TRAP until illegal_clr.
module instr_decoder_fsm #(
  parameter int INSTR_W     = 16,
  parameter int OP_W        = 4,
  parameter int REG_W       = 4,
  parameter int IMM_W       = 8,
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ir_valid,
  input  logic [INSTR_W-1:0] instruction,
  output logic               dec_ready,
  input  logic               ex_ack,
  output logic               alu_str,
  output logic               mov_str,
  output logic               ldst_str,
  output logic [OP_W-1:0]    opcode,
  output logic [REG_W-1:0]   rd,
  output logic [REG_W-1:0]   rs,
  output logic [IMM_W-1:0]   imm,
  output logic               imm_sel,
  output logic               is_store,
  output logic               timeout,
  output logic               illegal,
  input  logic               illegal_clr
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
`ifdef DEC_ILLEGAL_TRAP_EN
  localparam logic [1:0] S_TRAP  = 2'd3;
`else
  localparam logic [1:0] S_BYP   = 2'd2;
`endif

  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SUBI  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_ALU_HI = OP_W'(8);
  localparam logic [OP_W-1:0] OP_MOVI  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_MOV_HI = OP_W'(10);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(12);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dec_ready, r_alu, r_mov, r_ldst, r_timeout, r_illegal;
  logic             r_imm_sel, r_is_store;
  logic [OP_W-1:0]  r_op;
  logic [REG_W-1:0] r_rd, r_rs;
  logic [IMM_W-1:0] r_imm;

  logic [OP_W-1:0]  w_op;
  logic             w_defined, w_expire;

  assign w_op      = instruction[INSTR_W-1 -: OP_W];
  assign w_defined = (w_op <= OP_STORE);
  assign w_expire  = (ACK_TIMEOUT != 0) && (r_cnt == CNT_W'(ACK_TIMEOUT - 1));

`ifndef DEC_ILLEGAL_TRAP_EN
  logic w_unused_clr;
  assign w_unused_clr = illegal_clr;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_dec_ready <= 1'b1;
      r_alu       <= 1'b0;
      r_mov       <= 1'b0;
      r_ldst      <= 1'b0;
      r_timeout   <= 1'b0;
      r_illegal   <= 1'b0;
      r_imm_sel   <= 1'b0;
      r_is_store  <= 1'b0;
      r_op        <= '0;
      r_rd        <= '0;
      r_rs        <= '0;
      r_imm       <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: if (ir_valid) begin
          r_op        <= w_op;
          r_rd        <= instruction[INSTR_W-OP_W-1 -: REG_W];
          r_rs        <= instruction[INSTR_W-OP_W-REG_W-1 -: REG_W];
          r_imm       <= instruction[IMM_W-1:0];
          r_imm_sel   <= (w_op == OP_ADDI) || (w_op == OP_SUBI) || (w_op == OP_MOVI);
          r_is_store  <= (w_op == OP_STORE);
          r_dec_ready <= 1'b0;
          if (w_defined) begin
            r_state <= S_ISSUE;
            r_cnt   <= '0;
            r_alu   <= (w_op <= OP_ALU_HI);
            r_mov   <= (w_op > OP_ALU_HI) && (w_op <= OP_MOV_HI);
            r_ldst  <= (w_op > OP_MOV_HI);
          end else begin
`ifdef DEC_ILLEGAL_TRAP_EN
            r_state   <= S_TRAP;
            r_illegal <= 1'b1;
`else
            r_state   <= S_BYP;
`endif
          end
        end
        S_ISSUE: begin
          // ack takes priority over a timeout expiring on the same edge
          if (ex_ack || w_expire) begin
            r_state     <= S_IDLE;
            r_dec_ready <= 1'b1;
            r_alu       <= 1'b0;
            r_mov       <= 1'b0;
            r_ldst      <= 1'b0;
            r_timeout   <= !ex_ack;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`ifdef DEC_ILLEGAL_TRAP_EN
        S_TRAP: if (illegal_clr) begin
          r_state     <= S_IDLE;
          r_illegal   <= 1'b0;
          r_dec_ready <= 1'b1;
        end
`else
        S_BYP: begin
          r_state     <= S_IDLE;
          r_dec_ready <= 1'b1;
        end
`endif
        default: begin
          r_state     <= S_IDLE;
          r_dec_ready <= 1'b1;
          r_alu       <= 1'b0;
          r_mov       <= 1'b0;
          r_ldst      <= 1'b0;
          r_illegal   <= 1'b0;
        end
      endcase
    end
  end

  assign dec_ready = r_dec_ready;
  assign alu_str   = r_alu;
  assign mov_str   = r_mov;
  assign ldst_str  = r_ldst;
  assign opcode    = r_op;
  assign rd        = r_rd;
  assign rs        = r_rs;
  assign imm       = r_imm;
  assign imm_sel   = r_imm_sel;
  assign is_store  = r_is_store;
  assign timeout   = r_timeout;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_instr_decoder_fsm.sv
// Directed bench for instr_decoder_fsm: transaction-level model checked every cycle plus literal spot checks.
module tb_instr_decoder_fsm;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ir_valid = 1'b0;
  logic [15:0] instruction = '0;
  logic        ex_ack = 1'b0;
  logic        illegal_clr = 1'b0;
  logic        dec_ready, alu_str, mov_str, ldst_str, imm_sel, is_store, timeout, illegal;
  logic [3:0]  opcode, rd, rs;
  logic [7:0]  imm;

  int checks = 0;
  int errors = 0;

  instr_decoder_fsm #(.INSTR_W(16), .OP_W(4), .REG_W(4), .IMM_W(8),
                      .ACK_TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .ir_valid(ir_valid), .instruction(instruction),
    .dec_ready(dec_ready), .ex_ack(ex_ack), .alu_str(alu_str), .mov_str(mov_str),
    .ldst_str(ldst_str), .opcode(opcode), .rd(rd), .rs(rs), .imm(imm),
    .imm_sel(imm_sel), .is_store(is_store), .timeout(timeout), .illegal(illegal),
    .illegal_clr(illegal_clr));

  always #5 clk = ~clk;

  // Model: one outstanding transaction, described by its class and how long it has waited.
  bit       m_busy = 0, m_byp = 0, m_trap = 0, m_to = 0;
  int       m_cls = 0, m_age = 0;
  bit [3:0] m_op = 0, m_rd = 0, m_rs = 0;
  bit [7:0] m_imm = 0;
  bit       m_isel = 0, m_st = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 0; m_byp = 0; m_trap = 0; m_to = 0; m_age = 0; m_cls = 0;
      m_op = 0; m_rd = 0; m_rs = 0; m_imm = 0; m_isel = 0; m_st = 0;
    end else begin
      m_to = 0;
      if (m_busy) begin
        if (ex_ack) m_busy = 0;
        else if (TO > 0 && m_age + 1 == TO) begin m_busy = 0; m_to = 1; end
        else m_age++;
      end else if (m_byp) m_byp = 0;
      else if (m_trap) begin
        if (illegal_clr) m_trap = 0;
      end else if (ir_valid) begin
        m_op = instruction[15:12]; m_rd = instruction[11:8];
        m_rs = instruction[7:4];   m_imm = instruction[7:0];
        m_isel = (m_op == 1 || m_op == 3 || m_op == 9);
        m_st = (m_op == 12);
        if (m_op <= 12) begin
          m_busy = 1; m_age = 0;
          m_cls = (m_op <= 8) ? 0 : (m_op <= 10) ? 1 : 2;
        end else begin
`ifdef DEC_ILLEGAL_TRAP_EN
          m_trap = 1;
`else
          m_byp = 1;
`endif
        end
      end
    end
  end

  function automatic bit [5:0] exp_ctl();
    bit [2:0] s;
    s = !m_busy ? 3'b000 : (m_cls == 0) ? 3'b100 : (m_cls == 1) ? 3'b010 : 3'b001;
    return {!(m_busy || m_byp || m_trap), s, m_to, m_trap};
  endfunction

  always @(negedge clk) begin
    checks++;
    if ({dec_ready, alu_str, mov_str, ldst_str, timeout, illegal} !== exp_ctl()) begin
      errors++;
      $display("FAIL ctl t=%0t got %b want %b", $time,
               {dec_ready, alu_str, mov_str, ldst_str, timeout, illegal}, exp_ctl());
    end
    checks++;
    if ({opcode, rd, rs, imm, imm_sel, is_store} !== {m_op, m_rd, m_rs, m_imm, m_isel, m_st}) begin
      errors++;
      $display("FAIL fields t=%0t got %h want %h", $time,
               {opcode, rd, rs, imm, imm_sel, is_store}, {m_op, m_rd, m_rs, m_imm, m_isel, m_st});
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h want %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  initial begin
    int n;
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tick(); tick();
    chk("rst_ready", dec_ready, 1);
    chk("rst_strobes", {alu_str, mov_str, ldst_str}, 0);
    chk("rst_fields", {opcode, rd, rs, imm}, 0);
    reset = 1'b1;
    tick();

    // ADDI held for 4 strobe cycles
    instruction = 16'h1A5F; ir_valid = 1; tick(); ir_valid = 0;
    chk("addi_fields", {rd, rs, imm, imm_sel}, {4'hA, 4'h5, 8'h5F, 1'b1});
    chk("addi_ready", dec_ready, 0);
    for (int i = 0; i < 4; i++) begin
      chk("addi_str", alu_str, 1);
      if (i == 3) ex_ack = 1;
      tick();
    end
    ex_ack = 0;
    chk("addi_done_str", alu_str, 0);
    chk("addi_done_ready", dec_ready, 1);

    // STORE with ack held, then back-to-back ADD
    instruction = 16'hC300; ir_valid = 1; ex_ack = 1; tick();
    chk("st_str", ldst_str, 1);
    chk("st_flag", is_store, 1);
    instruction = 16'h0123; tick();
    chk("st_1cyc", ldst_str, 0);
    chk("st_ignored_fields", opcode, 4'hC);
    tick();
    chk("add_str", alu_str, 1);
    chk("add_fields", {opcode, rd, rs, imm}, {4'h0, 4'h1, 4'h2, 8'h23});
    ir_valid = 0; tick(); ex_ack = 0;
    chk("add_ready", dec_ready, 1);

    // MOV with no ack times out
    instruction = 16'hA210; ir_valid = 1; tick(); ir_valid = 0;
    n = 0;
    while (mov_str && n < 40) begin n++; tick(); end
    chk("mov_width", n, TO);
    chk("mov_timeout", timeout, 1);
    chk("mov_ready", dec_ready, 1);
    chk("mov_rd_hold", rd, 4'h2);
    tick();
    chk("mov_pulse1", timeout, 0);

    // undefined opcode
    instruction = 16'hE000; ir_valid = 1; tick(); ir_valid = 0;
    chk("ill_strobes", {alu_str, mov_str, ldst_str}, 0);
    chk("ill_ready", dec_ready, 0);
    chk("ill_op", opcode, 4'hE);
`ifdef DEC_ILLEGAL_TRAP_EN
    chk("ill_flag", illegal, 1);
    tick(); tick();
    chk("trap_hold", {illegal, dec_ready}, 2'b10);
    illegal_clr = 1; tick(); illegal_clr = 0;
    chk("trap_clr", {illegal, dec_ready}, 2'b01);
`else
    chk("ill_flag", illegal, 0);
    tick();
    chk("byp_ready", dec_ready, 1);
`endif

    // ack and illegal_clr in IDLE do nothing
    ex_ack = 1; illegal_clr = 1; tick(); ex_ack = 0; illegal_clr = 0;
    chk("idle_ack", {dec_ready, alu_str, mov_str, ldst_str, illegal}, 5'b10000);

    // new word during ISSUE is ignored
    instruction = 16'h5123; ir_valid = 1; tick();
    instruction = 16'h7FFF; tick(); tick();
    chk("issue_ignore", {opcode, rd, rs}, {4'h5, 4'h1, 4'h2});
    chk("issue_str", alu_str, 1);
    ir_valid = 0; ex_ack = 1; tick(); ex_ack = 0;

    // async reset mid-ISSUE
    instruction = 16'h0456; ir_valid = 1; tick(); ir_valid = 0;
    chk("pre_rst_str", alu_str, 1);
    #4 reset = 0;
    #1;
    chk("arst_strobes", {alu_str, mov_str, ldst_str}, 0);
    chk("arst_fields", {opcode, rd, rs, imm}, 0);
    chk("arst_ready", dec_ready, 1);
    tick(); reset = 1; tick(); tick();
    chk("post_rst", {dec_ready, alu_str, mov_str, ldst_str}, 4'b1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
